// File: rtl/systolic_pkg.sv
// systolic_pkg: shared widths, sizes and drain FSM states for the systolic wrapper.
package systolic_pkg;
    localparam int DATA_W   = 16;
    localparam int ARR_SIZE = 4;
    localparam int ELEMS    = ARR_SIZE * ARR_SIZE;
    typedef enum logic {IDLE, STREAM} drain_state_t;
endpackage

// File: rtl/systolic_elem_sel.sv
// systolic_elem_sel: picks one N-bit element from a flattened matrix by linear index.
// Optional negative-to-zero clamp when SYSTOLIC_DRAIN_RELU_EN is defined.
module systolic_elem_sel #(
    parameter int N    = 16,
    parameter int SIZE = 4,
    parameter int KW   = 4
) (
    input  logic [N*SIZE*SIZE-1:0] flat_in,
    input  logic [KW-1:0]          idx,
    output logic [N-1:0]           elem
);
    logic [N-1:0] raw;
    assign raw = flat_in[idx*N +: N];
`ifdef SYSTOLIC_DRAIN_RELU_EN
    assign elem = raw[N-1] ? '0 : raw;
`else
    assign elem = raw;
`endif
endmodule

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: double-buffered capture of a flattened result matrix, streamed
// row-major one element per beat. Optional clamp: SYSTOLIC_DRAIN_RELU_EN.
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int N    = DATA_W,
    parameter int SIZE = ARR_SIZE,
    parameter int IDXW = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N*SIZE*SIZE-1:0] z_flat_in,
    input  logic                   z_valid_in,
    output logic [N-1:0]           out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IDXW-1:0]        out_row,
    output logic [IDXW-1:0]        out_col,
    output logic                   out_last,
    output logic                   pending_full,
    output logic [7:0]             drop_cnt
);
    localparam int EL = SIZE * SIZE;
    localparam int KW = (EL > 1) ? $clog2(EL) : 1;
    localparam int MW = N * EL;
    localparam logic [KW-1:0] K_LAST = KW'(EL - 1);

    drain_state_t  state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [MW-1:0] act_q, act_d, pend_q, pend_d;
    logic          pend_full_q, pend_full_d;
    logic [7:0]    drop_q, drop_d;
    logic          fire, last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            act_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            act_q       <= act_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            drop_q      <= drop_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        act_d       = act_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        drop_d      = drop_q;
        fire        = (state_q == STREAM) && out_ready;
        last        = fire && (k_q == K_LAST);
        if (fire) k_d = k_q + 1'b1;
        if (last) begin
            k_d = '0;
            if (pend_full_q) begin
                act_d       = pend_q;
                pend_full_d = 1'b0;
            end else begin
                state_d = IDLE;
            end
        end
        // An arrival goes straight to active whenever active is (or is about to be) free.
        if (z_valid_in) begin
            if (state_q == IDLE || (last && !pend_full_q)) begin
                act_d   = z_flat_in;
                k_d     = '0;
                state_d = STREAM;
            end else if (!pend_full_q || last) begin
                pend_d      = z_flat_in;
                pend_full_d = 1'b1;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    systolic_elem_sel #(.N(N), .SIZE(SIZE), .KW(KW)) u_sel (
        .flat_in (act_q),
        .idx     (k_q),
        .elem    (out_data)
    );

    assign out_valid    = (state_q == STREAM);
    assign out_row      = IDXW'(k_q / KW'(SIZE));
    assign out_col      = IDXW'(k_q % KW'(SIZE));
    assign out_last     = out_valid && (k_q == K_LAST);
    assign pending_full = pend_full_q;
    assign drop_cnt     = drop_q;
endmodule

// File: tb/tb_systolic_result_drain.sv
// tb_systolic_result_drain: matrix-level queue model checked every cycle, plus directed
// scenarios with literal expectations on the accepted beat log.
module tb_systolic_result_drain;
    localparam int N = 16;
    localparam int E = 16;

    logic             clk = 0;
    logic             reset = 0;
    logic [N*E-1:0]   z = '0;
    logic             zv = 0;
    logic             rdy = 0;
    logic [N-1:0]     out_data;
    logic             out_valid, out_last, pending_full;
    logic [1:0]       out_row, out_col;
    logic [7:0]       drop_cnt;

    int checks = 0;
    int errors = 0;
    bit run = 0;

    logic [N-1:0]   mq[$];
    logic [N*E-1:0] pend_m = '0;
    bit             pend_v = 0;
    int             drops = 0;
    logic [19:0]    log_q[$];

    always #5 clk = ~clk;

    systolic_result_drain dut (
        .clk(clk), .reset(reset), .z_flat_in(z), .z_valid_in(zv),
        .out_data(out_data), .out_valid(out_valid), .out_ready(rdy),
        .out_row(out_row), .out_col(out_col), .out_last(out_last),
        .pending_full(pending_full), .drop_cnt(drop_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] relu(input logic [N-1:0] x);
`ifdef SYSTOLIC_DRAIN_RELU_EN
        return x[N-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    function automatic logic [N*E-1:0] mkm(input logic [N-1:0] base);
        logic [N*E-1:0] m;
        for (int i = 0; i < E; i++) m[i*N +: N] = base + N'(i);
        return m;
    endfunction

    task automatic load(input logic [N*E-1:0] m);
        mq.delete();
        for (int i = 0; i < E; i++) mq.push_back(m[i*N +: N]);
    endtask

    // Model: active matrix is a queue of remaining elements; pending is one stored matrix.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            pend_v = 0;
            drops = 0;
        end else begin
            bit lf;
            lf = (mq.size() == 1) && rdy;
            if (mq.size() > 0 && rdy) void'(mq.pop_front());
            if (lf && pend_v) begin
                load(pend_m);
                pend_v = 0;
            end
            if (zv) begin
                if (mq.size() == 0) load(z);
                else if (!pend_v) begin
                    pend_m = z;
                    pend_v = 1;
                end else drops++;
            end
        end
    end

    always @(negedge clk) begin
        if (run && !reset) begin
            int idx;
            idx = E - mq.size();
            chk("valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
            chk("pending_full", {31'd0, pending_full}, {31'd0, pend_v});
            chk("drop_cnt", {24'd0, drop_cnt}, (drops > 255) ? 255 : drops);
            chk("last", {31'd0, out_last}, {31'd0, (mq.size() == 1)});
            if (mq.size() > 0) begin
                chk("data", {16'd0, out_data}, {16'd0, relu(mq[0])});
                chk("row", {30'd0, out_row}, idx / 4);
                chk("col", {30'd0, out_col}, idx % 4);
            end
            if (out_valid && rdy) log_q.push_back({out_row, out_col, out_data});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [N*E-1:0] m);
        z = m;
        zv = 1;
        step(1);
        zv = 0;
    endtask

    task automatic chk_log(input string name, input int i, input logic [19:0] exp);
        if (i < log_q.size()) chk(name, {12'd0, log_q[i]}, {12'd0, exp});
        else chk({name, "_missing"}, log_q.size(), i + 1);
    endtask

    initial begin
        logic [N*E-1:0] rm;
        logic [1:0] pat [4];
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
        #1 reset = 1;
        #3;
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_data", {16'd0, out_data}, 0);
        chk("rst_rowcol", {28'd0, out_row, out_col}, 0);
        chk("rst_last", {31'd0, out_last}, 0);
        chk("rst_pend", {31'd0, pending_full}, 0);
        chk("rst_drop", {24'd0, drop_cnt}, 0);
        step(2);
        reset = 0;
        run = 1;

        // Basic drain
        rdy = 1;
        log_q.delete();
        pulse(mkm(16'd1));
        step(20);
        chk("basic_count", log_q.size(), 16);
        chk_log("basic_first", 0, {2'd0, 2'd0, 16'd1});
        chk_log("basic_mid", 6, {2'd1, 2'd2, 16'd7});
        chk_log("basic_lastbeat", 15, {2'd3, 2'd3, 16'd16});

        // Backpressure 1,0,0,1
        log_q.delete();
        pulse(mkm(16'd1));
        for (int c = 0; c < 60; c++) begin
            rdy = pat[c % 4][0];
            step(1);
        end
        rdy = 1;
        step(4);
        chk("bp_count", log_q.size(), 16);
        for (int i = 0; i < 16; i++) chk_log("bp_seq", i, {2'(i / 4), 2'(i % 4), 16'(i + 1)});

        // Double buffer
        log_q.delete();
        pulse(mkm(16'h0100));
        step(2);
        pulse(mkm(16'h0200));
        step(40);
        chk("dbl_count", log_q.size(), 32);
        chk_log("dbl_a_last", 15, {2'd3, 2'd3, 16'h010F});
        chk_log("dbl_b_first", 16, {2'd0, 2'd0, 16'h0200});
        chk_log("dbl_b_last", 31, {2'd3, 2'd3, 16'h020F});

        // Drop
        log_q.delete();
        rdy = 0;
        pulse(mkm(16'h0100));
        pulse(mkm(16'h0200));
        pulse(mkm(16'h0300));
        step(2);
        chk("drop_lit", {24'd0, drop_cnt}, 1);
        chk("drop_pend_lit", {31'd0, pending_full}, 1);
        rdy = 1;
        step(40);
        chk("drop_count", log_q.size(), 32);
        for (int i = 0; i < 32; i++)
            chk_log("drop_seq", i, {2'((i % 16) / 4), 2'(i % 4), 16'((i < 16 ? 16'h0100 : 16'h0200) + 16'(i % 16))});

        // Reset mid-stream after 5 beats
        log_q.delete();
        pulse(mkm(16'h0500));
        step(5);
        chk("mid_beats", log_q.size(), 5);
        #2 reset = 1;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 0);
        chk("mid_rst_data", {16'd0, out_data}, 0);
        chk("mid_rst_rowcol", {28'd0, out_row, out_col}, 0);
        chk("mid_rst_last", {31'd0, out_last}, 0);
        chk("mid_rst_pend", {31'd0, pending_full}, 0);
        chk("mid_rst_drop", {24'd0, drop_cnt}, 0);
        step(2);
        reset = 0;
        log_q.delete();
        pulse(mkm(16'h0600));
        step(20);
        chk("post_rst_count", log_q.size(), 16);
        chk_log("post_rst_first", 0, {2'd0, 2'd0, 16'h0600});

        // Sign handling
        rm = mkm(16'h0001);
        rm[0*N +: N] = 16'hFFFF;
        rm[1*N +: N] = 16'h8000;
        rm[2*N +: N] = 16'h7FFF;
        rm[3*N +: N] = 16'h0000;
        log_q.delete();
        pulse(rm);
        step(20);
`ifdef SYSTOLIC_DRAIN_RELU_EN
        chk_log("relu_0", 0, {2'd0, 2'd0, 16'h0000});
        chk_log("relu_1", 1, {2'd0, 2'd1, 16'h0000});
`else
        chk_log("raw_0", 0, {2'd0, 2'd0, 16'hFFFF});
        chk_log("raw_1", 1, {2'd0, 2'd1, 16'h8000});
`endif
        chk_log("sign_2", 2, {2'd0, 2'd2, 16'h7FFF});
        chk_log("sign_3", 3, {2'd0, 2'd3, 16'h0000});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Consumer side of the systolic wrapper's flattened result bus.
- Captures a flattened SIZE x SIZE result matrix on each output_valid pulse.
- Serializes the matrix one element per beat, row-major, over a valid/ready stream to the pooling/activation stage.
- Double-buffered (active + pending), so back-to-back matrices are absorbed while the downstream stream stalls.

Parameters:
- N, 16, element bit width (two's complement).
- SIZE, 4, matrix dimension; SIZE*SIZE elements per matrix.
- IDXW, $clog2(SIZE), width of row/column index outputs (minimum 1).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- z_flat_in  input  N*SIZE*SIZE  flattened result matrix; element (r,c) at bits [((r*SIZE+c+1)*N-1) -: N].
- z_valid_in  input  1  single-cycle pulse: z_flat_in holds a new matrix this cycle.
- out_data  output  N  current element.
- out_valid  output  1  out_data/out_row/out_col/out_last are valid.
- out_ready  input  1  downstream accepts the beat when out_valid && out_ready.
- out_row  output  IDXW  row index of current element.
- out_col  output  IDXW  column index of current element.
- out_last  output  1  high on element (SIZE-1,SIZE-1).
- pending_full  output  1  pending buffer occupied; the next capture is dropped unless the active matrix finishes that same cycle.
- drop_cnt  output  8  count of dropped matrices, saturating at 255.

Behaviour:
- Reset (asynchronous, any state): out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, pending_full=0, drop_cnt=0, both buffers invalid, element index=0, FSM=IDLE.
- Element index k counts 0..SIZE*SIZE-1.
  - out_row = k / SIZE; out_col = k % SIZE.
  - out_data = active_buf[((k+1)*N-1) -: N].
  - All outputs are driven from registers or from a mux of registered state only; no combinational path from z_flat_in or out_ready to any output.
- FSM states: IDLE, STREAM.
- IDLE:
  - z_valid_in=1: copy z_flat_in into the active buffer, k=0, go to STREAM.
  - out_valid rises the cycle after the pulse (latency 1).
- STREAM:
  - out_valid=1.
  - Beat fires when out_ready=1; k increments on each beat.
  - out_valid holds, and outputs hold stable, while out_ready=0.
- Last beat (k=SIZE*SIZE-1 fires):
  - Pending buffer valid: move pending to active, k=0, clear pending_full, stay in STREAM. No bubble; element 0 of the next matrix is presented the following cycle.
  - Pending buffer empty: go to IDLE, out_valid=0 next cycle.
- z_valid_in during STREAM:
  - Pending empty: capture into pending, pending_full=1 next cycle.
  - Pending full, last beat firing the same cycle: pending moves to active and the new matrix is captured into pending. No drop.
  - Pending full, otherwise: matrix discarded, drop_cnt += 1 (saturating at 255).
- z_valid_in in IDLE on the same cycle as reset deassertion: captured normally.
- out_last = (k == SIZE*SIZE-1) && out_valid.
- Data passes through unmodified; no arithmetic except the optional clamp below.

Optional Feature:
- Macro: SYSTOLIC_DRAIN_RELU_EN.
- Defined:
  - out_data = 0 when the selected element's MSB is 1 (negative); otherwise the element unchanged.
  - Clamp is applied in the output mux; no added latency.
- Undefined: out_data is the raw element; no clamp logic is present.

Decomposition:
- Shared package systolic_pkg holds:
  - constants DATA_W=16 and ARR_SIZE=4;
  - localparam ELEMS = ARR_SIZE*ARR_SIZE;
  - enum drain_state_t {IDLE, STREAM}.
- One natural sub-module: systolic_elem_sel. Combinational N-bit element mux from the flattened buffer by index, including the optional clamp; reusable by the operand feeder.

Test Plan:
- Basic drain: pulse z_valid_in with element k = k+1 (1..16), out_ready=1 constantly -> 16 consecutive beats starting 1 cycle after the pulse, data 1..16, row/col (0,0)..(3,3), out_last only on the 16th beat, then out_valid=0.
- Backpressure: same matrix, out_ready toggles 1,0,0,1 repeatedly -> out_data/row/col held stable while stalled; all 16 values delivered in order with no duplicates.
- Double buffer: matrix A (values 0x0100+k) then matrix B (0x0200+k) pulsed 3 cycles later, out_ready=1 -> 32 contiguous beats, A then B, no bubble between A's last and B's first; pending_full high from 1 cycle after B's pulse until A's last beat.
- Drop: out_ready=0; pulse A, B, C -> A active, B pending, C dropped, drop_cnt=1; release out_ready -> A then B streamed, C never appears.
- Reset mid-stream: assert reset after beat 5 of a matrix -> all outputs 0 immediately (asynchronous); after release, a new pulse streams from element (0,0).
- With SYSTOLIC_DRAIN_RELU_EN: elements 0xFFFF, 0x8000, 0x7FFF, 0x0000 -> out_data 0x0000, 0x0000, 0x7FFF, 0x0000. Without the macro -> values pass through unchanged.
